rle_sprite_decoder: RTL and testbench

RLE_SPRITE_DECODER -- requirements
Module: rle_sprite_decoder

---
 rtl/rle_sprite_decoder.sv | 188 ++++++++++++++++++
 tb/tb_rle_sprite_decoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_sprite_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rle_sprite_decoder                                              |
// | Purpose  : Expands a run-length table into a raster stream of pixel colours |
// |            (optional RLE_TRANSPARENCY_EN adds a colour-key output)          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rle_sprite_decoder #(
    parameter int                 IMG_W         = 584,
    parameter int                 IMG_H         = 167,
    parameter int                 COLOR_W       = 12,
    parameter int                 MAX_RUNS      = 64,
    parameter int                 LEN_W         = 17,
    parameter logic [COLOR_W-1:0] DEFAULT_COLOR = '0
`ifdef RLE_TRANSPARENCY_EN
    ,
    parameter logic [COLOR_W-1:0] TRANSPARENT_KEY = COLOR_W'(12'hF0F)
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        run_wr_en,
    input  logic [$clog2(MAX_RUNS)-1:0] run_wr_addr,
    input  logic [LEN_W-1:0]            run_wr_len,
    input  logic [COLOR_W-1:0]          run_wr_color,
    input  logic                        frame_start,
    input  logic                        pix_en,
    output logic [COLOR_W-1:0]          color_data,
    output logic                        pix_valid,
    output logic                        busy,
    output logic                        frame_done
`ifdef RLE_TRANSPARENCY_EN
    ,
    output logic                        transparent
`endif
);

    localparam int               c_aw    = $clog2(MAX_RUNS);
    localparam logic [LEN_W-1:0] c_total = LEN_W'(IMG_W * IMG_H);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [LEN_W-1:0]   r_run_len   [MAX_RUNS];
    logic [COLOR_W-1:0] r_run_color [MAX_RUNS];

    logic [LEN_W-1:0]   r_pix_cnt, w_pix_cnt_nxt;
    logic [LEN_W-1:0]   r_remain,  w_remain_nxt;
    logic [c_aw-1:0]    r_run_idx, w_run_idx_nxt;
    logic [COLOR_W-1:0] r_cur_color, w_cur_color_nxt;
    logic               r_exhausted, w_exhausted_nxt;
    logic               r_done_pend, w_done_pend_nxt;
    logic [COLOR_W-1:0] w_color_nxt;
    logic               w_valid_nxt;
    logic [c_aw-1:0]    w_rd_addr;
    logic [LEN_W-1:0]   w_rd_len;
    logic [COLOR_W-1:0] w_rd_color;

    assign busy = (r_state == S_LOAD) || (r_state == S_RUN);

    // Single read port: entry 0 while loading, otherwise the entry after the current run.
    assign w_rd_addr  = (r_state == S_RUN) ? r_run_idx + c_aw'(1) : '0;
    assign w_rd_len   = r_run_len[w_rd_addr];
    assign w_rd_color = r_run_color[w_rd_addr];

    always_ff @(posedge clk) begin
        if (run_wr_en && !busy) begin
            r_run_len[run_wr_addr]   <= run_wr_len;
            r_run_color[run_wr_addr] <= run_wr_color;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pix_cnt_nxt   = r_pix_cnt;
        w_remain_nxt    = r_remain;
        w_run_idx_nxt   = r_run_idx;
        w_cur_color_nxt = r_cur_color;
        w_exhausted_nxt = r_exhausted;
        w_done_pend_nxt = 1'b0;
        w_color_nxt     = color_data;
        w_valid_nxt     = 1'b0;

        if (frame_start) begin
            w_state_nxt     = S_LOAD;
            w_pix_cnt_nxt   = '0;
            w_remain_nxt    = '0;
            w_run_idx_nxt   = '0;
            w_exhausted_nxt = 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (pix_en) begin
                        w_color_nxt = DEFAULT_COLOR;
                    end
                    if (w_rd_len == '0) begin
                        w_state_nxt     = S_DONE;
                        w_exhausted_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = S_RUN;
                        w_remain_nxt    = w_rd_len;
                        w_cur_color_nxt = w_rd_color;
                    end
                end
                S_RUN: begin
                    if (pix_en) begin
                        w_valid_nxt   = 1'b1;
                        w_color_nxt   = r_exhausted ? DEFAULT_COLOR : r_cur_color;
                        w_pix_cnt_nxt = r_pix_cnt + LEN_W'(1);
                        if (w_pix_cnt_nxt == c_total) begin
                            w_state_nxt     = S_DONE;
                            w_done_pend_nxt = 1'b1;
                        end else if (!r_exhausted) begin
                            if (r_remain == LEN_W'(1)) begin
                                // Fetch the next run now so it starts on the very next pixel.
                                if ((r_run_idx == c_aw'(MAX_RUNS - 1)) || (w_rd_len == '0)) begin
                                    w_exhausted_nxt = 1'b1;
                                    w_remain_nxt    = '0;
                                end else begin
                                    w_run_idx_nxt   = r_run_idx + c_aw'(1);
                                    w_remain_nxt    = w_rd_len;
                                    w_cur_color_nxt = w_rd_color;
                                end
                            end else begin
                                w_remain_nxt = r_remain - LEN_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    if (pix_en) begin
                        w_color_nxt = DEFAULT_COLOR;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_cnt   <= '0;
            r_remain    <= '0;
            r_run_idx   <= '0;
            r_cur_color <= DEFAULT_COLOR;
            r_exhausted <= 1'b0;
            r_done_pend <= 1'b0;
            color_data  <= DEFAULT_COLOR;
            pix_valid   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            r_pix_cnt   <= w_pix_cnt_nxt;
            r_remain    <= w_remain_nxt;
            r_run_idx   <= w_run_idx_nxt;
            r_cur_color <= w_cur_color_nxt;
            r_exhausted <= w_exhausted_nxt;
            r_done_pend <= w_done_pend_nxt;
            color_data  <= w_color_nxt;
            pix_valid   <= w_valid_nxt;
            frame_done  <= r_done_pend;
        end
    end

`ifdef RLE_TRANSPARENCY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            transparent <= 1'b0;
        end else begin
            transparent <= w_valid_nxt && (w_color_nxt == TRANSPARENT_KEY);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rle_sprite_decoder.sv
`default_nettype none
// Randomised self-checking bench for rle_sprite_decoder on a reduced 20x10 sprite.
module tb_rle_sprite_decoder;

    localparam int          IMG_W    = 20;
    localparam int          IMG_H    = 10;
    localparam int          NPIX     = IMG_W * IMG_H;
    localparam int          COLOR_W  = 12;
    localparam int          MAX_RUNS = 8;
    localparam int          LEN_W    = 17;
    localparam int          AW       = 3;
    localparam logic [11:0] DEF      = 12'h123;
    localparam logic [11:0] KEY      = 12'hF0F;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              run_wr_en = 1'b0;
    logic [AW-1:0]     run_wr_addr = '0;
    logic [LEN_W-1:0]  run_wr_len = '0;
    logic [11:0]       run_wr_color = '0;
    logic              frame_start = 1'b0;
    logic              pix_en = 1'b0;
    logic [11:0]       color_data;
    logic              pix_valid;
    logic              busy;
    logic              frame_done;
`ifdef RLE_TRANSPARENCY_EN
    logic              transparent;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    int          tcount = 0;
    int          tbl_len [MAX_RUNS];
    logic [11:0] tbl_col [MAX_RUNS];
    logic [11:0] exp_pix [NPIX];

    rle_sprite_decoder #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .COLOR_W(COLOR_W), .MAX_RUNS(MAX_RUNS),
        .LEN_W(LEN_W), .DEFAULT_COLOR(DEF)
`ifdef RLE_TRANSPARENCY_EN
        , .TRANSPARENT_KEY(KEY)
`endif
    ) dut (
        .clk(clk), .reset(reset), .run_wr_en(run_wr_en), .run_wr_addr(run_wr_addr),
        .run_wr_len(run_wr_len), .run_wr_color(run_wr_color), .frame_start(frame_start),
        .pix_en(pix_en), .color_data(color_data), .pix_valid(pix_valid), .busy(busy),
        .frame_done(frame_done)
`ifdef RLE_TRANSPARENCY_EN
        , .transparent(transparent)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference image: expand runs in order, stop at a zero length or the table end,
    // clip at the frame size and pad the rest with the default colour.
    function automatic void build_expect();
        int p;
        p = 0;
        for (int i = 0; i < MAX_RUNS; i++) begin
            if (tbl_len[i] == 0) break;
            for (int k = 0; k < tbl_len[i]; k++) begin
                if (p < NPIX) begin
                    exp_pix[p] = tbl_col[i];
                    p++;
                end
            end
        end
        while (p < NPIX) begin
            exp_pix[p] = DEF;
            p++;
        end
    endfunction

    task automatic load_table();
        for (int i = 0; i < MAX_RUNS; i++) begin
            run_wr_en    = 1'b1;
            run_wr_addr  = AW'(i);
            run_wr_len   = LEN_W'(tbl_len[i]);
            run_wr_color = tbl_col[i];
            tick();
        end
        run_wr_en = 1'b0;
    endtask

    task automatic check_pixel(input int p);
        chk("pixel", color_data, exp_pix[p]);
`ifdef RLE_TRANSPARENCY_EN
        chk("transparent", transparent, exp_pix[p] == KEY);
        if (transparent) tcount++;
`endif
    endtask

    // pmode 0: pix_en held high; pmode 1: pix_en random.
    task automatic run_frame(input int pmode);
        int   p;
        int   guard;
        logic en;
        build_expect();
        frame_start = 1'b1;
        pix_en      = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("start_no_pix", pix_valid, 1'b0);
        chk("busy_load", busy, 1'b1);
        pix_en = (pmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
        chk("load_no_pix", pix_valid, 1'b0);
        p = 0;
        guard = 0;
        while (p < NPIX && guard < 2000) begin
            en = (pmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            pix_en = en;
            tick();
            guard++;
            chk("valid", pix_valid, en);
            chk("no_early_done", frame_done, 1'b0);
            if (en) begin
                check_pixel(p);
                p++;
            end
            chk("busy", busy, p < NPIX);
        end
        if (p < NPIX) chk("timeout_pixels", p, NPIX);
        pix_en = 1'b0;
        tick();
        chk("frame_done", frame_done, 1'b1);
        chk("busy_done", busy, 1'b0);
        chk("valid_after", pix_valid, 1'b0);
        tick();
        chk("done_once", frame_done, 1'b0);
    endtask

    initial begin
        int p;

        // Reset values
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_color", color_data, DEF);
        chk("rst_valid", pix_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        pix_en = 1'b1;
        tick();
        chk("idle_valid", pix_valid, 1'b0);
        chk("idle_color", color_data, DEF);
        pix_en = 1'b0;

        // Single-pixel runs back to back
        for (int i = 0; i < MAX_RUNS; i++) begin tbl_len[i] = 0; tbl_col[i] = 12'h000; end
        tbl_len[0] = 1; tbl_col[0] = 12'hAAA;
        tbl_len[1] = 1; tbl_col[1] = 12'h555;
        tbl_len[2] = 2; tbl_col[2] = 12'hF00;
        load_table();
        run_frame(0);

        // Two runs then terminator, default-colour tail
        tbl_len[0] = 150; tbl_col[0] = 12'h000;
        tbl_len[1] = 43;  tbl_col[1] = 12'hFFF;
        tbl_len[2] = 0;
        load_table();
        run_frame(1);

        // Overlong run truncated at the last pixel; then pix_en in DONE
        tbl_len[0] = 100; tbl_col[0] = 12'h0AB;
        tbl_len[1] = 150; tbl_col[1] = 12'h0CD;
        tbl_len[2] = 0;
        load_table();
        run_frame(1);
        chk("done_hold_color", color_data, 12'h0CD);
        pix_en = 1'b1;
        tick();
        chk("done_default", color_data, DEF);
        chk("done_valid", pix_valid, 1'b0);
        pix_en = 1'b0;

        // Every entry used; table ends by index
        for (int i = 0; i < MAX_RUNS; i++) begin tbl_len[i] = 10; tbl_col[i] = 12'(16 * i + 1); end
        load_table();
        run_frame(1);

        // Random tables
        repeat (6) begin
            for (int i = 0; i < MAX_RUNS; i++) begin
                tbl_len[i] = $urandom_range(1, 60);
                tbl_col[i] = 12'($urandom);
            end
            if ($urandom_range(0, 2) == 0) tbl_len[$urandom_range(1, MAX_RUNS - 1)] = 0;
            load_table();
            run_frame(1);
        end

        // Abort mid-frame, write while busy, restart
        for (int i = 0; i < MAX_RUNS; i++) begin tbl_len[i] = 30; tbl_col[i] = 12'(12'h200 + i); end
        load_table();
        build_expect();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        pix_en = 1'b1;
        tick();
        p = 0;
        repeat (50) begin
            tick();
            chk("abort_pre_valid", pix_valid, 1'b1);
            check_pixel(p);
            p++;
        end
        run_wr_en = 1'b1; run_wr_addr = '0; run_wr_len = LEN_W'(5); run_wr_color = 12'hBAD;
        tick();
        run_wr_en = 1'b0;
        check_pixel(p);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("abort_no_pix", pix_valid, 1'b0);
        chk("abort_no_done", frame_done, 1'b0);
        tick();
        chk("abort_load_no_pix", pix_valid, 1'b0);
        chk("abort_load_no_done", frame_done, 1'b0);
        tick();
        chk("restart_valid", pix_valid, 1'b1);
        chk("restart_pix0", color_data, exp_pix[0]);

        // Reset with frame_start high in RUN
        reset = 1'b1;
        frame_start = 1'b1;
        tick();
        reset = 1'b0;
        frame_start = 1'b0;
        chk("mid_rst_color", color_data, DEF);
        chk("mid_rst_valid", pix_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", frame_done, 1'b0);
        tick();
        chk("mid_rst_idle_valid", pix_valid, 1'b0);
        chk("mid_rst_idle_busy", busy, 1'b0);
        pix_en = 1'b0;

        // Table survives reset and the dropped busy write
        run_frame(1);

        // Colour-key run
        for (int i = 0; i < MAX_RUNS; i++) begin tbl_len[i] = 0; tbl_col[i] = 12'h000; end
        tbl_len[0] = 3; tbl_col[0] = KEY;
        load_table();
        tcount = 0;
        run_frame(1);
`ifdef RLE_TRANSPARENCY_EN
        chk("transparent_count", tcount, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
